// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86 icode constants and 2-bit counter helpers
// Purpose: instruction codes used by fetch-side prediction and saturating
//          counter arithmetic for the branch history table.
// Ports:   none (package).
package y86_pkg;

  localparam logic [3:0] IJXX   = 4'h7;
  localparam logic [3:0] ICALL  = 4'h8;
  localparam logic [3:0] IRET   = 4'h9;
  localparam logic [3:0] ALWAYS = 4'h0;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address stack with checkpoint restore
// Purpose: holds predicted return addresses; push overwrites the oldest entry
//          when full, pop on empty is ignored.
// Ports:   clk, rst_n        clock, async active-low reset
//          push, pop, wdata  fetch-side stack operations
//          restore, ckpt_in  reload {count,tos} after a branch mispredict
//          flush             empty the stack (ret mispredict)
//          top               entry at tos
//          ckpt_out          current {count,tos}
//          empty             count == 0
module ras_stack #(
  parameter int ADDR_W    = 64,
  parameter int RAS_DEPTH = 8,
  localparam int PW       = $clog2(RAS_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              restore,
  input  logic              flush,
  input  logic [2*PW:0]     ckpt_in,
  input  logic [ADDR_W-1:0] wdata,
  output logic [ADDR_W-1:0] top,
  output logic [2*PW:0]     ckpt_out,
  output logic              empty
);

  localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PW:0]       count;
  logic [PW-1:0]     tos;
  logic [PW-1:0]     tos_inc;
  logic [PW-1:0]     tos_dec;

  assign tos_inc  = tos + 1'b1;
  assign tos_dec  = tos - 1'b1;
  assign top      = mem[tos];
  assign ckpt_out = {count, tos};
  assign empty    = (count == '0);

  // Entries are not rolled back on restore: a wrong-path push may have
  // clobbered a slot, and W catches the resulting bad ret prediction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      tos   <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      count <= '0;
      tos   <= '0;
    end else if (restore) begin
      {count, tos} <= ckpt_in;
    end else if (push) begin
      tos          <= tos_inc;
      mem[tos_inc] <= wdata;
      if (count != FULL) count <= count + 1'b1;
    end else if (pop && !empty) begin
      tos   <= tos_dec;
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pc_predictor.sv
// rtl/pc_predictor.sv - fetch PC register with bimodal BHT and RAS prediction
// Purpose: holds the fetch PC, predicts the next PC (calls, jXX via 2-bit
//          counters, rets via RAS) and redirects on M/W mispredicts.
// Ports:   clk, rst_n                       clock, async active-low reset
//          f_stall, f_icode, f_ifun,
//          f_valC, f_valP                   fetch-stage inputs
//          f_pc, f_pred_taken, f_ras_ckpt,
//          f_ret_pred                       fetch PC and prediction sideband
//          m_*                              resolved conditional jXX in M
//          w_*                              resolved ret in W
//          m_mispredict, w_mispredict       redirect flags to pipe control
module pc_predictor
  import y86_pkg::*;
#(
  parameter int              ADDR_W      = 64,
  parameter int              BHT_ENTRIES = 16,
  parameter int              RAS_DEPTH   = 8,
  parameter logic [1:0]      CTR_INIT    = 2'b10,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  localparam int             IDX_W       = $clog2(BHT_ENTRIES),
  localparam int             PW          = $clog2(RAS_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_stall,
  input  logic [3:0]        f_icode,
  input  logic [3:0]        f_ifun,
  input  logic [ADDR_W-1:0] f_valC,
  input  logic [ADDR_W-1:0] f_valP,
  output logic [ADDR_W-1:0] f_pc,
  output logic              f_pred_taken,
  output logic [2*PW:0]     f_ras_ckpt,
  output logic [ADDR_W-1:0] f_ret_pred,
  input  logic              m_br_valid,
  input  logic [ADDR_W-1:0] m_pc,
  input  logic              m_cnd,
  input  logic              m_pred_taken,
  input  logic [ADDR_W-1:0] m_valC,
  input  logic [ADDR_W-1:0] m_valP,
  input  logic [2*PW:0]     m_ras_ckpt,
  input  logic              w_ret_valid,
  input  logic [ADDR_W-1:0] w_ret_pred,
  input  logic [ADDR_W-1:0] w_valM,
  output logic              m_mispredict,
  output logic              w_mispredict
);

  logic [1:0]        bht [BHT_ENTRIES];
  logic [ADDR_W-1:0] next_pc;
  logic              fetch_push;
  logic              fetch_pop;
  logic              redirect;
  logic              ras_advance;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;
  logic              unused_m_pc;

  assign unused_m_pc = ^m_pc[ADDR_W-1:IDX_W];

  assign m_mispredict = m_br_valid & (m_cnd != m_pred_taken);
  assign w_mispredict = w_ret_valid & (w_valM != w_ret_pred);
  assign redirect     = m_mispredict | w_mispredict;
  assign ras_advance  = !redirect && !f_stall;

  // An empty RAS falls back to the fall-through address; W corrects it.
  assign f_ret_pred = ras_empty ? f_valP : ras_top;

  always_comb begin
    next_pc      = f_valP;
    f_pred_taken = 1'b0;
    fetch_push   = 1'b0;
    fetch_pop    = 1'b0;
    unique case (f_icode)
      ICALL: begin
        next_pc      = f_valC;
        f_pred_taken = 1'b1;
        fetch_push   = 1'b1;
      end
      IJXX: begin
        // Fetch reads the counter before any same-cycle M update lands.
        f_pred_taken = (f_ifun == ALWAYS) ? 1'b1 : bht[f_pc[IDX_W-1:0]][1];
        next_pc      = f_pred_taken ? f_valC : f_valP;
      end
      IRET: begin
        next_pc   = f_ret_pred;
        fetch_pop = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            f_pc <= RESET_PC;
    else if (w_mispredict) f_pc <= w_valM;
    else if (m_mispredict) f_pc <= m_cnd ? m_valC : m_valP;
    else if (!f_stall)     f_pc <= next_pc;
  end

  // Training follows M regardless of stall or W redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CTR_INIT;
    end else if (m_br_valid) begin
      bht[m_pc[IDX_W-1:0]] <= m_cnd ? ctr_inc(bht[m_pc[IDX_W-1:0]])
                                    : ctr_dec(bht[m_pc[IDX_W-1:0]]);
    end
  end

  ras_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fetch_push & ras_advance),
    .pop      (fetch_pop & ras_advance),
    .restore  (m_mispredict),
    .flush    (w_mispredict),
    .ckpt_in  (m_ras_ckpt),
    .wdata    (f_valP),
    .top      (ras_top),
    .ckpt_out (f_ras_ckpt),
    .empty    (ras_empty)
  );

endmodule

// File: tb/tb_pc_predictor.sv
// tb/tb_pc_predictor.sv - self-checking bench for pc_predictor
module tb_pc_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_stall;
  logic [3:0]  f_icode, f_ifun;
  logic [63:0] f_valC, f_valP, f_pc, f_ret_pred;
  logic        f_pred_taken;
  logic [6:0]  f_ras_ckpt;
  logic        m_br_valid, m_cnd, m_pred_taken;
  logic [63:0] m_pc, m_valC, m_valP;
  logic [6:0]  m_ras_ckpt;
  logic        w_ret_valid;
  logic [63:0] w_ret_pred, w_valM;
  logic        m_mispredict, w_mispredict;

  int n_cmp = 0;
  int n_mis = 0;
  logic [63:0] exp_q [$];
  string       name_q [$];
  logic [63:0] got, exp_v;
  string       nm;

  pc_predictor dut (
    .clk(clk), .rst_n(rst_n), .f_stall(f_stall), .f_icode(f_icode), .f_ifun(f_ifun),
    .f_valC(f_valC), .f_valP(f_valP), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
    .f_ras_ckpt(f_ras_ckpt), .f_ret_pred(f_ret_pred), .m_br_valid(m_br_valid),
    .m_pc(m_pc), .m_cnd(m_cnd), .m_pred_taken(m_pred_taken), .m_valC(m_valC),
    .m_valP(m_valP), .m_ras_ckpt(m_ras_ckpt), .w_ret_valid(w_ret_valid),
    .w_ret_pred(w_ret_pred), .w_valM(w_valM), .m_mispredict(m_mispredict),
    .w_mispredict(w_mispredict)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] vc, input logic [63:0] vp);
    f_icode = ic; f_ifun = fn; f_valC = vc; f_valP = vp;
  endtask

  task automatic expect_v(input string n, input logic [63:0] v);
    name_q.push_back(n);
    exp_q.push_back(v);
  endtask

  task automatic test_reset();
    fetch(4'h1, 4'h0, 64'h0, 64'h40);
    expect_v("pc_before_reset", 64'h40);
    tick();
    got = f_pc; exp_v = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, exp_v); end
    rst_n = 1'b0;
    expect_v("reset_pc", 64'h0);
    expect_v("reset_ckpt", 64'h0);
    #1;
    got = f_pc; exp_v = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, exp_v); end
    got = 64'(f_ras_ckpt); exp_v = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, exp_v); end
    tick();
    rst_n = 1'b1;
    fetch(4'h1, 4'h0, 64'h0, 64'h3);
    tick();
    fetch(4'h7, 4'h1, 64'h55, 64'h5C);
    expect_v("init_ctr_taken", 64'h1);
    expect_v("init_ctr_pc", 64'h55);
    #1;
    got = 64'(f_pred_taken); exp_v = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, exp_v); end
    tick();
    got = f_pc; exp_v = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, exp_v); end
  endtask

  task automatic test_loop_training();
    fetch(4'h1, 4'h0, 64'h0, 64'h10);
    tick();
    f_stall = 1'b1;
    m_br_valid = 1'b1; m_pc = 64'h10; m_cnd = 1'b0; m_pred_taken = 1'b0;
    expect_v("train_no_mispredict", 64'h0);
    #1;
    got = 64'(m_mispredict); exp_v = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, exp_v); end
    expect_v("stall_holds_pc", 64'h10);
    tick();
    tick();
    got = f_pc; exp_v = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, exp_v); end
    m_br_valid = 1'b0; f_stall = 1'b0;
    fetch(4'h7, 4'h4, 64'h80, 64'h19);
    expect_v("trained_not_taken", 64'h0);
    expect_v("trained_pc", 64'h19);
    #1;
    got = 64'(f_pred_taken); exp_v = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, exp_v); end
    tick();
    got = f_pc; exp_v = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, exp_v); end
  endtask

  task automatic test_call_ret();
    fetch(4'h8, 4'h0, 64'h100, 64'h2A);
    expect_v("call_pc", 64'h100);
    expect_v("call_ckpt", 64'h9);
    tick();
    got = f_pc; exp_v = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, exp_v); end
    got = 64'(f_ras_ckpt); exp_v = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, exp_v); end
    fetch(4'h9, 4'h0, 64'h0, 64'h102);
    expect_v("ret_pred", 64'h2A);
    expect_v("ret_pc", 64'h2A);
    #1;
    got = f_ret_pred; exp_v = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, exp_v); end
    tick();
    got = f_pc; exp_v = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, exp_v); end
  endtask

  task automatic test_ras_overflow();
    for (int k = 1; k <= 9; k++) begin
      fetch(4'h8, 4'h0, 64'h500 + 64'(k) * 64'h20, 64'h1000 + 64'(k) * 64'h10);
      expect_v("nested_call_pc", 64'h500 + 64'(k) * 64'h20);
      tick();
      got = f_pc; exp_v = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_mis++; $display("FAIL %s[%0d]: got %h want %h", nm, k, got, exp_v); end
    end
    expect_v("full_ckpt", 64'h41);
    got = 64'(f_ras_ckpt); exp_v = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, exp_v); end
    for (int k = 1; k <= 9; k++) begin
      fetch(4'h9, 4'h0, 64'h0, 64'h3333);
      expect_v("nested_ret_pc", (k <= 8) ? 64'h1000 + 64'(10 - k) * 64'h10 : 64'h3333);
      tick();
      got = f_pc; exp_v = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_mis++; $display("FAIL %s[%0d]: got %h want %h", nm, k, got, exp_v); end
    end
    fetch(4'h8, 4'h0, 64'h777, 64'h778);
    w_ret_valid = 1'b1; w_ret_pred = 64'h3333; w_valM = 64'h1010;
    expect_v("w_mispredict_flag", 64'h1);
    expect_v("w_redirect_pc", 64'h1010);
    expect_v("w_flush_ckpt", 64'h0);
    #1;
    got = 64'(w_mispredict); exp_v = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, exp_v); end
    tick();
    got = f_pc; exp_v = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, exp_v); end
    got = 64'(f_ras_ckpt); exp_v = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, exp_v); end
    w_ret_pred = 64'h55; w_valM = 64'h55;
    expect_v("w_correct_ret", 64'h0);
    #1;
    got = 64'(w_mispredict); exp_v = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, exp_v); end
    w_ret_valid = 1'b0;
  endtask

  task automatic test_m_mispredict_stall();
    fetch(4'h8, 4'h0, 64'h300, 64'h31);
    tick();
    f_stall = 1'b1;
    fetch(4'h8, 4'h0, 64'h999, 64'h998);
    m_br_valid = 1'b1; m_pc = 64'h21; m_cnd = 1'b1; m_pred_taken = 1'b0;
    m_valC = 64'h80; m_valP = 64'h88; m_ras_ckpt = 7'd29;
    expect_v("m_mispredict_flag", 64'h1);
    expect_v("m_redirect_pc", 64'h80);
    expect_v("m_restore_ckpt", 64'd29);
    #1;
    got = 64'(m_mispredict); exp_v = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, exp_v); end
    tick();
    got = f_pc; exp_v = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, exp_v); end
    got = 64'(f_ras_ckpt); exp_v = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, exp_v); end
    m_br_valid = 1'b0;
    fetch(4'h9, 4'h0, 64'h0, 64'hABC);
    expect_v("restored_top", 64'h1050);
    expect_v("stall_pc_hold", 64'h80);
    expect_v("stall_ckpt_hold", 64'd29);
    #1;
    got = f_ret_pred; exp_v = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, exp_v); end
    tick();
    got = f_pc; exp_v = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, exp_v); end
    got = 64'(f_ras_ckpt); exp_v = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, exp_v); end
    f_stall = 1'b0;
  endtask

  task automatic test_simultaneous();
    fetch(4'h1, 4'h0, 64'h0, 64'h123);
    m_br_valid = 1'b1; m_pc = 64'h06; m_cnd = 1'b1; m_pred_taken = 1'b0;
    m_valC = 64'h80; m_valP = 64'h90; m_ras_ckpt = 7'd29;
    w_ret_valid = 1'b1; w_ret_pred = 64'h0; w_valM = 64'h200;
    expect_v("both_flags", 64'h3);
    expect_v("w_wins_pc", 64'h200);
    expect_v("w_wins_ckpt", 64'h0);
    #1;
    got = {62'h0, m_mispredict, w_mispredict}; exp_v = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, exp_v); end
    tick();
    got = f_pc; exp_v = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, exp_v); end
    got = 64'(f_ras_ckpt); exp_v = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, exp_v); end
    w_ret_valid = 1'b0;
    m_cnd = 1'b0;
    fetch(4'h1, 4'h0, 64'h0, 64'h206);
    tick();
    m_br_valid = 1'b0;
    fetch(4'h7, 4'h2, 64'h400, 64'h20B);
    expect_v("bht_updated_in_w_cycle", 64'h1);
    expect_v("bht_updated_pc", 64'h400);
    #1;
    got = 64'(f_pred_taken); exp_v = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, exp_v); end
    tick();
    got = f_pc; exp_v = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, exp_v); end
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    expect_v("async_reset_pc", 64'h0);
    expect_v("async_reset_bht", 64'h1);
    #1;
    got = f_pc; exp_v = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, exp_v); end
    got = 64'(f_pred_taken); exp_v = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_mis++; $display("FAIL %s: got %h want %h", nm, got, exp_v); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; f_stall = 1'b0;
    fetch(4'h1, 4'h0, 64'h0, 64'h0);
    m_br_valid = 1'b0; m_pc = '0; m_cnd = 1'b0; m_pred_taken = 1'b0;
    m_valC = '0; m_valP = '0; m_ras_ckpt = '0;
    w_ret_valid = 1'b0; w_ret_pred = '0; w_valM = '0;
    tick();
    tick();
    rst_n = 1'b1;
    test_reset();
    test_loop_training();
    test_call_ret();
    test_ras_overflow();
    test_m_mispredict_stall();
    test_simultaneous();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
